// File: rtl/dsa_host_pkg.sv
// DSA host bridge shared definitions.
// Opcodes, response codes, FSM states and state-class helpers.
package dsa_host_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'hAA;
  localparam logic [7:0] RSP_NAK   = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_WR_DATA,
    ST_WR_BUS,
    ST_RD_BUS,
    ST_RD_SEND,
    ST_ACK_SEND,
    ST_NAK_SEND
  } host_state_t;

  typedef logic [8:0] len_t;

  // States that wait on the host and run the inter-byte timer
  function automatic logic st_waiting(host_state_t s);
    return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) ||
           (s == ST_LEN)     || (s == ST_WR_DATA);
  endfunction

  // States that take a byte from the host link
  function automatic logic st_rx(host_state_t s);
    return (s == ST_IDLE) || st_waiting(s);
  endfunction

endpackage

// File: rtl/dsa_host_bridge.sv
// Host byte-stream to DSA memory bus bridge.
// Parses write/read bursts, drives the bus, returns data or ACK/NAK.
module dsa_host_bridge
  import dsa_host_pkg::*;
#(
  parameter int RD_LATENCY     = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_wr_en,
  output logic        bus_rd_en,
  input  logic [7:0]  bus_rdata,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_badcmd
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(RD_LATENCY + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_LATENCY);

  host_state_t   state_q, state_d;
  logic          wr_op_q, wr_op_d;
  logic [15:0]   addr_q, addr_d;
  len_t          len_q, len_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          rx_ready_q, rx_ready_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          err_to_q, err_to_d;
  logic          err_bad_q, err_bad_d;
  logic          rx_acc;

  assign rx_acc = rx_valid && rx_ready_q;

  // Next-state, datapath and inter-byte timeout
  always_comb begin
    state_d    = state_q;
    wr_op_d    = wr_op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    timer_d    = '0;
    rd_cnt_d   = '0;
    err_to_d   = 1'b0;
    err_bad_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (rx_acc) begin
        if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
          state_d = ST_ADDR_HI;
          wr_op_d = (rx_data == CMD_WRITE);
        end else begin
          state_d    = ST_NAK_SEND;
          err_bad_d  = 1'b1;
          tx_data_d  = RSP_NAK;
          tx_valid_d = 1'b1;
        end
      end
      ST_ADDR_HI: if (rx_acc) begin
        addr_d[15:8] = rx_data;
        state_d      = ST_ADDR_LO;
      end
      ST_ADDR_LO: if (rx_acc) begin
        addr_d[7:0] = rx_data;
        state_d     = ST_LEN;
      end
      ST_LEN: if (rx_acc) begin
        len_d   = (rx_data == 8'h00) ? len_t'(256) : {1'b0, rx_data};
        state_d = wr_op_q ? ST_WR_DATA : ST_RD_BUS;
      end
      ST_WR_DATA: if (rx_acc) begin
        wdata_d = rx_data;
        state_d = ST_WR_BUS;
      end
      ST_WR_BUS: begin
        addr_d = addr_q + 16'd1;
        len_d  = len_q - len_t'(1);
        if (len_q == len_t'(1)) begin
          state_d    = ST_ACK_SEND;
          tx_data_d  = RSP_ACK;
          tx_valid_d = 1'b1;
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      ST_RD_BUS: begin
        if (rd_cnt_q == RD_LAST) begin
          state_d    = ST_RD_SEND;
          tx_data_d  = bus_rdata;
          tx_valid_d = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
      end
      ST_RD_SEND: if (tx_ready) begin
        tx_valid_d = 1'b0;
        addr_d     = addr_q + 16'd1;
        len_d      = len_q - len_t'(1);
        state_d    = (len_q == len_t'(1)) ? ST_IDLE : ST_RD_BUS;
      end
      ST_ACK_SEND, ST_NAK_SEND: if (tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (st_waiting(state_q) && !rx_acc) begin
      if (timer_q == TMO_LAST) begin
        state_d  = ST_IDLE;
        err_to_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
    rx_ready_d = st_rx(state_d);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_op_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      timer_q    <= '0;
      rd_cnt_q   <= '0;
      err_to_q   <= 1'b0;
      err_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_op_q    <= wr_op_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
      timer_q    <= timer_d;
      rd_cnt_q   <= rd_cnt_d;
      err_to_q   <= err_to_d;
      err_bad_q  <= err_bad_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_wr_en   = (state_q == ST_WR_BUS);
  assign bus_rd_en   = (state_q == ST_RD_BUS);
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_to_q;
  assign err_badcmd  = err_bad_q;

endmodule

// File: tb/tb_dsa_host_bridge.sv
// Self-checking bench for dsa_host_bridge.
// Two instances: RD_LATENCY 0 and 1, both with a 16-cycle timeout.
module tb_dsa_host_bridge;
  import dsa_host_pkg::*;

  typedef struct {
    logic        lat1;
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        stall;
    logic [7:0]  rsp;
    int          rd_cyc;
    int          bad;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       sel;
  logic       stall;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;

  logic        rx_ready0, tx_valid0, wr0, rd0, busy0, eto0, ebad0;
  logic        rx_ready1, tx_valid1, wr1, rd1, busy1, eto1, ebad1;
  logic [7:0]  tx_data0, wdata0, rdata0, tx_data1, wdata1, rdata1;
  logic [15:0] addr0, addr1;
  logic        rv0, rv1, tr0, tr1;

  logic        rx_rdy, tx_v, m_wr, m_rd, m_busy, m_eto, m_ebad;
  logic [7:0]  tx_d, m_wdata;
  logic [15:0] m_addr;

  logic [7:0] bank  [0:65535];
  logic [7:0] model [0:65535];

  logic [7:0]  exp_tx[$];
  logic [23:0] exp_wr[$];

  int checks = 0;
  int errors = 0;
  int rd_cyc = 0;
  int bad_cnt = 0;
  int to_cnt = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_d = 8'h00;

  assign rv0 = rx_valid & ~sel;
  assign rv1 = rx_valid & sel;
  assign tr0 = tx_ready & ~sel;
  assign tr1 = tx_ready & sel;

  assign rx_rdy  = sel ? rx_ready1 : rx_ready0;
  assign tx_v    = sel ? tx_valid1 : tx_valid0;
  assign tx_d    = sel ? tx_data1 : tx_data0;
  assign m_wr    = sel ? wr1 : wr0;
  assign m_rd    = sel ? rd1 : rd0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_eto   = sel ? eto1 : eto0;
  assign m_ebad  = sel ? ebad1 : ebad0;
  assign m_wdata = sel ? wdata1 : wdata0;
  assign m_addr  = sel ? addr1 : addr0;

  assign rdata0 = bank[addr0];
  always @(posedge clk) rdata1 <= bank[addr1];
  always @(posedge clk) if (m_wr) bank[m_addr] = m_wdata;

  dsa_host_bridge #(.RD_LATENCY(0), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rv0), .rx_ready(rx_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tr0),
    .bus_addr(addr0), .bus_wdata(wdata0), .bus_wr_en(wr0),
    .bus_rd_en(rd0), .bus_rdata(rdata0), .busy(busy0),
    .err_timeout(eto0), .err_badcmd(ebad0)
  );

  dsa_host_bridge #(.RD_LATENCY(1), .TIMEOUT_CYCLES(16)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rv1), .rx_ready(rx_ready1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tr1),
    .bus_addr(addr1), .bus_wdata(wdata1), .bus_wr_en(wr1),
    .bus_rd_en(rd1), .bus_rdata(rdata1), .busy(busy1),
    .err_timeout(eto1), .err_badcmd(ebad1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("tx_hold_valid", tx_v, 1);
        chk("tx_hold_data", tx_d, hold_d);
      end
      hold   = tx_v && !tx_ready;
      hold_d = tx_d;
      if (tx_v && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %02h expected none", tx_d);
        end else begin
          chk("tx_data", tx_d, exp_tx.pop_front());
        end
      end
      if (m_wr) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got %04h=%02h expected none",
                   m_addr, m_wdata);
        end else begin
          chk("bus_write", {m_addr, m_wdata}, exp_wr.pop_front());
        end
      end
      if (m_wr && m_rd) begin
        checks++; errors++;
        $display("FAIL strobe_overlap: got wr=1 rd=1 expected exclusive");
      end
      if (m_rd) rd_cyc++;
      if (m_ebad) bad_cnt++;
      if (m_eto) to_cnt++;
    end
  end

  task automatic rx_send(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rx_rdy) begin ok = 1'b1; break; end
    end
    chk("rx_accept", 32'(ok), 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!m_busy) begin ok = 1'b1; break; end
    end
    chk("idle_reached", 32'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_eto(output int k);
    bit seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      seen = m_eto;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic [15:0] a;
    logic [7:0] d;
    sel = v.lat1; stall = v.stall;
    @(posedge clk); #1;
    rd_cyc = 0; bad_cnt = 0; to_cnt = 0;
    n = (v.len == 8'h00) ? 256 : int'(v.len);
    for (int i = 0; i < n; i++) begin
      a = v.addr + 16'(i);
      if (v.op == CMD_WRITE) begin
        d = (i == 0) ? v.d0 : v.d1;
        model[a] = d;
        exp_wr.push_back({a, d});
      end else if (v.op == CMD_READ) begin
        exp_tx.push_back(model[a]);
      end
    end
    if (v.rsp != 8'h00) exp_tx.push_back(v.rsp);
    rx_send(v.op);
    if (v.op != CMD_WRITE && v.op != CMD_READ) begin
      chk("err_badcmd_pulse", 32'(m_ebad), 1);
    end else begin
      rx_send(v.addr[15:8]);
      rx_send(v.addr[7:0]);
      rx_send(v.len);
      if (v.op == CMD_WRITE)
        for (int i = 0; i < n; i++) rx_send((i == 0) ? v.d0 : v.d1);
    end
    wait_idle();
    chk("rd_cycles", rd_cyc, v.rd_cyc);
    chk("badcmd_count", bad_cnt, v.bad);
    chk("timeout_count", to_cnt, 0);
    chk("tx_left", exp_tx.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    stall = 1'b0;
  endtask

  initial begin
    vec_t vecs [8];
    vec_t vfin;
    int k;
    vecs[0] = '{1'b0, CMD_WRITE, 16'h0000, 8'd2, 8'h40, 8'h01, 1'b0,
                RSP_ACK, 0, 0};
    vecs[1] = '{1'b0, CMD_READ, 16'h0010, 8'd4, 8'h00, 8'h00, 1'b0,
                8'h00, 4, 0};
    vecs[2] = '{1'b1, CMD_READ, 16'h0010, 8'd4, 8'h00, 8'h00, 1'b0,
                8'h00, 8, 0};
    vecs[3] = '{1'b0, 8'h13, 16'h0000, 8'd0, 8'h00, 8'h00, 1'b0,
                RSP_NAK, 0, 1};
    vecs[4] = '{1'b0, CMD_WRITE, 16'h000C, 8'd1, 8'h01, 8'h00, 1'b0,
                RSP_ACK, 0, 0};
    vecs[5] = '{1'b0, CMD_WRITE, 16'hFFFF, 8'd2, 8'h11, 8'h22, 1'b0,
                RSP_ACK, 0, 0};
    vecs[6] = '{1'b0, CMD_READ, 16'hFFFF, 8'd2, 8'h00, 8'h00, 1'b1,
                8'h00, 2, 0};
    vecs[7] = '{1'b0, CMD_READ, 16'hFFFF, 8'd0, 8'h00, 8'h00, 1'b1,
                8'h00, 256, 0};
    vfin    = '{1'b0, CMD_WRITE, 16'h0200, 8'd1, 8'h77, 8'h00, 1'b0,
                RSP_ACK, 0, 0};

    for (int a = 0; a < 65536; a++) begin
      bank[a]  = 8'(a + 1) ^ 8'hA5;
      model[a] = bank[a];
    end
    bank[16] = 8'h01; bank[17] = 8'h00; bank[18] = 8'h00; bank[19] = 8'h00;
    model[16] = 8'h01; model[17] = 8'h00; model[18] = 8'h00; model[19] = 8'h00;

    sel = 1'b0; stall = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_ready = 1'b1; reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready0), 0);
    chk("rst_tx_valid", 32'(tx_valid0), 0);
    chk("rst_tx_data", 32'(tx_data0), 0);
    chk("rst_bus_addr", 32'(addr0), 0);
    chk("rst_strobes", {wr0, rd0, wr1, rd1}, 0);
    chk("rst_busy_err", {busy0, eto0, ebad0}, 0);
    reset_n = 1'b1;
    chk("rx_ready_pre_edge", 32'(rx_ready0), 0);
    @(posedge clk); #1;
    chk("rx_ready_rise", 32'(rx_ready0), 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Silence after ADDR_LO: abort 16 cycles after the last byte
    sel = 1'b0; to_cnt = 0;
    rx_send(CMD_WRITE); rx_send(8'h00); rx_send(8'h00);
    wait_eto(k);
    chk("timeout_latency", k, 16);
    chk("timeout_idle", 32'(m_busy), 0);
    @(posedge clk); #1;
    chk("timeout_width", 32'(m_eto), 0);
    chk("timeout_pulses", to_cnt, 1);
    chk("timeout_rx_ready", 32'(rx_rdy), 1);

    // Silence mid write burst: first byte stays written
    to_cnt = 0;
    model[16'h0020] = 8'hAB;
    exp_wr.push_back({16'h0020, 8'hAB});
    rx_send(CMD_WRITE); rx_send(8'h00); rx_send(8'h20); rx_send(8'h03);
    rx_send(8'hAB);
    wait_eto(k);
    chk("timeout_wr_seen", 32'(m_eto), 1);
    @(posedge clk); #1;
    chk("timeout_wr_left", exp_wr.size(), 0);
    chk("timeout_wr_tx", exp_tx.size(), 0);

    // Reset in the middle of a write burst
    model[16'h0100] = 8'h5C;
    exp_wr.push_back({16'h0100, 8'h5C});
    rx_send(CMD_WRITE); rx_send(8'h01); rx_send(8'h00); rx_send(8'h04);
    rx_send(8'h5C);
    @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy0), 0);
    chk("mid_rst_rx_ready", 32'(rx_ready0), 0);
    chk("mid_rst_addr", 32'(addr0), 0);
    chk("mid_rst_wdata", 32'(wdata0), 0);
    chk("mid_rst_out", {wr0, rd0, tx_valid0, eto0, ebad0}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rx_ready", 32'(rx_ready0), 1);
    chk("post_rst_wr_left", exp_wr.size(), 0);
    run_vec(vfin);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
